mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
- Performs word loads and stores on a req/ready data-memory bus that may insert wait states.
- Raises a pipeline stall while an access is outstanding.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY cycles without dmem_ready before the access is aborted with bus_err. 0 disables the timeout.
- CNT_W, 5, width of the wait-cycle counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- RegWrite_in  in  1  from EX/MEM
- MemtoReg_in  in  1  from EX/MEM
- MemRead_in  in  1  from EX/MEM: load
- MemWrite_in  in  1  from EX/MEM: store
- alu_result_in  in  32  from EX/MEM: effective address or ALU result
- write_data_in  in  32  from EX/MEM: store data
- dest_reg_in  in  5  from EX/MEM: destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_ready  in  1  memory completes the request this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- RegWrite_out  out  1  to WB
- MemtoReg_out  out  1  to WB
- read_data_out  out  32  to WB
- alu_result_out  out  32  to WB
- dest_reg_out  out  5  to WB
- misalign_err  out  1  one-cycle registered pulse
- bus_err  out  1  one-cycle registered pulse

Behaviour:
- Definitions:
  - mem_op = MemRead_in | MemWrite_in.
  - aligned = (alu_result_in[1:0] == 0).
  - MemRead_in and MemWrite_in are never both 1.
- Reset (rst=0, asynchronous):
  - State goes to IDLE and the counter to 0.
  - All registered outputs go to 0.
  - dmem_req and mem_stall are forced to 0 immediately.
  - An in-flight request is abandoned; the memory must tolerate this.
- FSM states: IDLE, BUSY.
- Bus outputs are combinational:
  - dmem_req = mem_op & aligned & (state==IDLE or state==BUSY).
  - dmem_we = MemWrite_in.
  - dmem_addr = {alu_result_in[31:2], 2'b00}.
  - dmem_wdata = write_data_in.
- Completion:
  - complete = !mem_op, or !aligned, or dmem_ready, or timeout.
  - mem_stall = !complete.
- IDLE:
  - Aligned mem_op with dmem_ready=0: go to BUSY, counter=1.
  - Otherwise: stay in IDLE.
- BUSY:
  - dmem_ready=1: go to IDLE, counter=0.
  - Timeout when TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES: go to IDLE, counter=0, access aborted.
  - Otherwise: counter increments.
- Upstream inputs are held stable while mem_stall=1. This stage does not re-sample them.
- MEM/WB register update on each clk edge:
  - Stalled: load a bubble. RegWrite_out=0, MemtoReg_out=0; data fields don't-care but held at their previous value.
  - Complete, normal: pass RegWrite, MemtoReg, alu_result and dest_reg through. read_data_out = dmem_rdata when a load completes with dmem_ready, otherwise it holds.
  - Misaligned load or store: no request issued. RegWrite_out=0 and misalign_err=1 for one cycle.
  - Timeout: RegWrite_out=0 and bus_err=1 for one cycle.
- Latency:
  - Zero-wait access or non-memory op: 1 cycle, same as a plain pipeline register.
  - Each wait cycle adds exactly one stall cycle and one bubble.
- dmem_ready while the stage is IDLE without a request is ignored.
- A timeout and dmem_ready in the same cycle: dmem_ready wins, normal completion.
- Counter never wraps; it saturates at TIMEOUT_CYCLES.

Decomposition:
- Shared package mips_pkg:
  - mem_state_t enum {IDLE, BUSY}
  - constants WORD_W=32, REG_ADDR_W=5
- Sub-module mem_wb: the MEM/WB register.
  - Inputs: bubble and capture enables.
  - Same asynchronous active-low reset.
- FSM, counter and bus logic stay in mem_stage.

Test Plan:
1. Zero-wait load: MemRead=1, RegWrite=1, MemtoReg=1, addr=0x100, dest=8, dmem_ready=1 with rdata=0xDEADBEEF in the same cycle -> mem_stall never high; next edge RegWrite_out=1, MemtoReg_out=1, read_data_out=0xDEADBEEF, dest_reg_out=8.
2. Three-wait store: MemWrite=1, addr=0x204, wdata=0x12345678, dmem_ready on the 4th cycle -> dmem_req and dmem_we high for 4 cycles, mem_stall high for 3 cycles, 3 bubbles (RegWrite_out=0), state returns to IDLE.
3. Misaligned load at addr=0x102, RegWrite=1 -> dmem_req stays 0, mem_stall=0, next edge misalign_err=1 for 1 cycle, RegWrite_out=0.
4. Timeout with TIMEOUT_CYCLES=4: load with dmem_ready held 0 -> stall for 4 cycles, then bus_err pulse, RegWrite_out=0, next instruction proceeds.
5. rst driven low while in BUSY after 2 wait cycles -> dmem_req and mem_stall drop immediately; all outputs 0; after release, a zero-wait ALU op (RegWrite=1, alu_result=0x55, dest=3) passes through in 1 cycle.
6. Back-to-back: ALU op, then load with 1 wait, then ALU op -> WB sequence is valid, bubble, valid load, valid ALU, in that order, with no lost or duplicated instruction.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS pipeline stages.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage and data memory.
// Latency: none (wires only); a request completes in the cycle ready is high.
// Backpressure: memory holds dmem_ready low to insert wait states.
interface mem_stage_if;
  import mips_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [WORD_W-1:0] dmem_addr;
  logic [WORD_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [WORD_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );

endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with bubble insertion and error pulse flops.
// Latency: 1 cycle from capture to outputs.
// Backpressure: bubble loads a no-op; data fields hold their previous value.
module mem_wb
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic                  capture,
  input  logic                  rdata_en,
  input  logic                  kill,
  input  logic                  misalign_in,
  input  logic                  bus_err_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [WORD_W-1:0]     alu_result_in,
  input  logic [WORD_W-1:0]     read_data_in,
  input  logic [REG_ADDR_W-1:0] dest_reg_in,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic [WORD_W-1:0]     alu_result_out,
  output logic [WORD_W-1:0]     read_data_out,
  output logic [REG_ADDR_W-1:0] dest_reg_out,
  output logic                  misalign_err,
  output logic                  bus_err
);

  logic                  reg_write_q,  reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [WORD_W-1:0]     alu_result_q, alu_result_d;
  logic [WORD_W-1:0]     read_data_q,  read_data_d;
  logic [REG_ADDR_W-1:0] dest_reg_q,   dest_reg_d;
  logic                  misalign_q,   misalign_d;
  logic                  bus_err_q,    bus_err_d;

  // Next register contents: bubble clears control, capture passes the instruction on.
  always_comb begin
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    dest_reg_d   = dest_reg_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    if (bubble) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (capture) begin
      reg_write_d  = reg_write_in & ~kill;
      mem_to_reg_d = mem_to_reg_in & ~kill;
      alu_result_d = alu_result_in;
      dest_reg_d   = dest_reg_in;
      misalign_d   = misalign_in;
      bus_err_d    = bus_err_in;
      if (rdata_en) begin
        read_data_d = read_data_in;
      end
    end
  end

  // Register state; error flags self-clear so they only pulse for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      dest_reg_q   <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      dest_reg_q   <= dest_reg_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign reg_write_out  = reg_write_q;
  assign mem_to_reg_out = mem_to_reg_q;
  assign alu_result_out = alu_result_q;
  assign read_data_out  = read_data_q;
  assign dest_reg_out   = dest_reg_q;
  assign misalign_err   = misalign_q;
  assign bus_err        = bus_err_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: word load/store over a req/ready bus, feeding the MEM/WB register.
// Latency: 1 cycle for zero-wait or non-memory ops; each wait cycle adds one stall.
// Backpressure: mem_stall holds upstream while an access waits; the timeout aborts with bus_err.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite_in,
  input  logic                  MemtoReg_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic [WORD_W-1:0]     alu_result_in,
  input  logic [WORD_W-1:0]     write_data_in,
  input  logic [REG_ADDR_W-1:0] dest_reg_in,
  mem_stage_if.master           dmem,
  output logic                  mem_stall,
  output logic                  RegWrite_out,
  output logic                  MemtoReg_out,
  output logic [WORD_W-1:0]     read_data_out,
  output logic [WORD_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] dest_reg_out,
  output logic                  misalign_err,
  output logic                  bus_err
);

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic mem_op;
  logic aligned;
  logic acc_ok;
  logic timeout;
  logic complete;
  logic misalign;
  logic abort;
  logic ld_done;

  assign mem_op   = MemRead_in | MemWrite_in;
  assign aligned  = (alu_result_in[1:0] == 2'b00);
  assign acc_ok   = mem_op & aligned;
  assign timeout  = TO_EN & (state_q == BUSY) & (cnt_q == TO_CNT);
  assign complete = ~mem_op | ~aligned | dmem.dmem_ready | timeout;
  assign misalign = mem_op & ~aligned;
  // A same-cycle ready beats the timeout, so abort only without ready.
  assign abort    = timeout & ~dmem.dmem_ready;
  assign ld_done  = MemRead_in & aligned & dmem.dmem_ready;

  // Bus is driven straight from the held EX/MEM fields; reset kills req at once.
  assign dmem.dmem_req   = acc_ok & rst;
  assign dmem.dmem_we    = MemWrite_in;
  assign dmem.dmem_addr  = {alu_result_in[WORD_W-1:2], 2'b00};
  assign dmem.dmem_wdata = write_data_in;
  assign mem_stall       = ~complete & rst;

  // Next state and wait counter; leaving BUSY on any completion condition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (acc_ok && !dmem.dmem_ready) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (complete) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_wb u_mem_wb (
    .clk            (clk),
    .rst            (rst),
    .bubble         (~complete),
    .capture        (complete),
    .rdata_en       (ld_done),
    .kill           (misalign | abort),
    .misalign_in    (misalign),
    .bus_err_in     (abort),
    .reg_write_in   (RegWrite_in),
    .mem_to_reg_in  (MemtoReg_in),
    .alu_result_in  (alu_result_in),
    .read_data_in   (dmem.dmem_rdata),
    .dest_reg_in    (dest_reg_in),
    .reg_write_out  (RegWrite_out),
    .mem_to_reg_out (MemtoReg_out),
    .alu_result_out (alu_result_out),
    .read_data_out  (read_data_out),
    .dest_reg_out   (dest_reg_out),
    .misalign_err   (misalign_err),
    .bus_err        (bus_err)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random instructions.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A watchdog ends the run if it ever stops advancing.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  dest_reg_in;
  logic        mem_stall, reg_write_out, mem_to_reg_out, misalign_err, bus_err;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  dest_reg_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_rdata  = 32'h0;

  mem_stage_if dif();

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .RegWrite_in    (reg_write_in),
    .MemtoReg_in    (mem_to_reg_in),
    .MemRead_in     (mem_read_in),
    .MemWrite_in    (mem_write_in),
    .alu_result_in  (alu_result_in),
    .write_data_in  (write_data_in),
    .dest_reg_in    (dest_reg_in),
    .dmem           (dif),
    .mem_stall      (mem_stall),
    .RegWrite_out   (reg_write_out),
    .MemtoReg_out   (mem_to_reg_out),
    .read_data_out  (read_data_out),
    .alu_result_out (alu_result_out),
    .dest_reg_out   (dest_reg_out),
    .misalign_err   (misalign_err),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(dif.dmem_req), 32'h0);
    chk({tag, "_stall"}, 32'(mem_stall), 32'h0);
    chk({tag, "_wbctl"}, 32'({reg_write_out, mem_to_reg_out, misalign_err, bus_err}), 32'h0);
    chk({tag, "_rdata"}, read_data_out, 32'h0);
    chk({tag, "_alu"},   alu_result_out, 32'h0);
    chk({tag, "_dest"},  32'(dest_reg_out), 32'h0);
  endtask

  // One instruction through the stage. waits = cycles before memory answers
  // (anything above TO means the memory never answers in time).
  task automatic run_instr(input logic rw, input logic mtr, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [4:0] dst, input int waits, input logic [31:0] rval);
    logic memop, algn, acc, to_err, normal;
    int   stalls;
    memop  = rd | wr;
    algn   = (addr[1:0] == 2'b00);
    acc    = memop & algn;
    stalls = acc ? ((waits < TO) ? waits : TO) : 0;
    to_err = acc && (waits > TO);
    normal = !(memop && !algn) && !to_err;

    reg_write_in  = rw;
    mem_to_reg_in = mtr;
    mem_read_in   = rd;
    mem_write_in  = wr;
    alu_result_in = addr;
    write_data_in = wdat;
    dest_reg_in   = dst;

    for (int k = 0; k <= stalls; k++) begin
      dif.dmem_ready = acc ? (k == waits) : 1'($urandom_range(0, 1));
      dif.dmem_rdata = (acc && k == waits) ? rval : $urandom;
      @(negedge clk);
      chk("dmem_req",   32'(dif.dmem_req), 32'(acc));
      chk("dmem_we",    32'(dif.dmem_we), 32'(wr));
      chk("dmem_addr",  dif.dmem_addr, {addr[31:2], 2'b00});
      chk("dmem_wdata", dif.dmem_wdata, wdat);
      chk("mem_stall",  32'(mem_stall), 32'(k < stalls));
      @(posedge clk);
      #1;
      if (k < stalls) begin
        chk("bubble_rw",   32'(reg_write_out), 32'h0);
        chk("bubble_mtr",  32'(mem_to_reg_out), 32'h0);
        chk("bubble_errs", 32'({misalign_err, bus_err}), 32'h0);
      end
    end

    if (rd && acc && !to_err) m_rdata = rval;
    chk("wb_regwrite", 32'(reg_write_out), 32'(rw & normal));
    chk("wb_misalign", 32'(misalign_err), 32'(memop & ~algn));
    chk("wb_bus_err",  32'(bus_err), 32'(to_err));
    chk("wb_rdata",    read_data_out, m_rdata);
    if (normal) begin
      chk("wb_memtoreg", 32'(mem_to_reg_out), 32'(mtr));
      chk("wb_alu",      alu_result_out, addr);
      chk("wb_dest",     32'(dest_reg_out), 32'(dst));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_tbl[8];
    int op;
    logic [31:0] a;
    wait_tbl = '{0, 0, 1, 2, 3, 4, 5, 99};

    // Aligned load presented during reset: request and stall must stay low.
    reg_write_in = 1'b1; mem_to_reg_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    alu_result_in = 32'h40; write_data_in = 32'h0; dest_reg_in = 5'd1;
    dif.dmem_ready = 1'b0; dif.dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");
    mem_read_in = 1'b0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
    rst = 1'b1;

    // Zero-wait load
    run_instr(1, 1, 1, 0, 32'h100, 32'h0, 5'd8, 0, 32'hDEADBEEF);
    // Store with three wait states
    run_instr(0, 0, 0, 1, 32'h204, 32'h12345678, 5'd0, 3, 32'h0);
    // Misaligned load
    run_instr(1, 1, 1, 0, 32'h102, 32'h0, 5'd9, 0, 32'hCAFEF00D);
    // Load that never answers: timeout
    run_instr(1, 1, 1, 0, 32'h300, 32'h0, 5'd10, 99, 32'h0);
    // Ready arriving exactly on the timeout cycle completes normally
    run_instr(1, 1, 1, 0, 32'h304, 32'h0, 5'd11, TO, 32'hA5A5_5A5A);
    // Following instruction proceeds normally
    run_instr(1, 0, 0, 0, 32'h77, 32'h0, 5'd12, 0, 32'h0);

    // Reset in the middle of a waiting load
    reg_write_in = 1'b1; mem_to_reg_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    alu_result_in = 32'h400; dest_reg_in = 5'd4;
    dif.dmem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_reset_stall", 32'(mem_stall), 32'h1);
    rst = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    chk_all_zero("held_reset");
    mem_read_in = 1'b0;
    rst = 1'b1;
    m_rdata = 32'h0;
    run_instr(1, 0, 0, 0, 32'h55, 32'h0, 5'd3, 0, 32'h0);

    // Back-to-back: ALU, one-wait load, ALU
    run_instr(1, 0, 0, 0, 32'h1111, 32'h0, 5'd5, 0, 32'h0);
    run_instr(1, 1, 1, 0, 32'h2220, 32'h0, 5'd6, 1, 32'h0BAD_F00D);
    run_instr(1, 0, 0, 0, 32'h3333, 32'h0, 5'd7, 0, 32'h0);

    // Random instruction mix
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case (op)
        0: run_instr(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, a, $urandom,
                     5'($urandom), 0, 32'h0);
        1: run_instr(1'b1, 1'b1, 1'b1, 1'b0, a, $urandom, 5'($urandom),
                     wait_tbl[$urandom_range(0, 7)], $urandom);
        2: run_instr(1'b0, 1'b0, 1'b0, 1'b1, a, $urandom, 5'($urandom),
                     wait_tbl[$urandom_range(0, 7)], $urandom);
        default: run_instr(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, a, $urandom,
                           5'($urandom), 0, 32'h0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
